mxint_block_quantizer: RTL and testbench

Serial fixed-point to MXINT block quantizer: collects BLOCK_SIZE signed fixed-point elements, one per handshake, derives a shared exponent from the largest magnitude, and emits one MXINT block. The block is emitted as BLOCK_SIZE signed mantissas plus one signed exponent. It is the producer that feeds MXINT operand streams (mantissa array + shared exponent) into the mxint linear/dot-product datapath.

---
 rtl/mxint_block_quantizer.sv | 135 +++++++++++++
 tb/tb_mxint_block_quantizer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mxint_block_quantizer.sv
// Serial fixed-point to MXINT block quantizer: gathers BLOCK_SIZE signed elements,
// derives a shared exponent from the largest magnitude and emits mantissas + exponent.
module mxint_block_quantizer #(
  parameter int unsigned DATA_IN_0_PRECISION_0  = 16,
  parameter int unsigned DATA_IN_0_PRECISION_1  = 8,
  parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
  parameter int unsigned DATA_OUT_0_PRECISION_1 = 8,
  parameter int unsigned BLOCK_SIZE             = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE-1:0],
  output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int unsigned W    = DATA_IN_0_PRECISION_0;
  localparam int unsigned Frac = DATA_IN_0_PRECISION_1;
  localparam int unsigned M    = DATA_OUT_0_PRECISION_0;
  localparam int unsigned E    = DATA_OUT_0_PRECISION_1;
  localparam int unsigned CntW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned ShW  = $clog2(W) + 1;
  localparam int          EMax = (1 << (E - 1)) - 1;
  localparam int          EMin = -(1 << (E - 1));

  typedef enum logic [1:0] {StCollect, StCalc, StEmit} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]        max_abs_q, max_abs_d;
  logic [W-1:0]        buffer_q [BLOCK_SIZE-1:0];
  logic [W-1:0]        buffer_d [BLOCK_SIZE-1:0];
  logic [M-1:0]        mdata_q [BLOCK_SIZE-1:0];
  logic [M-1:0]        mdata_d [BLOCK_SIZE-1:0];
  logic [E-1:0]        edata_q, edata_d;

  logic                in_accept;
  logic [W-1:0]        abs_in;
  logic [ShW-1:0]      lead;
  logic                shift_right;
  logic [ShW-1:0]      shamt;
  logic [M-1:0]        calc_mant [BLOCK_SIZE-1:0];
  int                  exp_raw;
  int                  exp_sat;

  assign data_in_0_ready  = rst && (state_q == StCollect);
  assign in_accept        = data_in_0_valid && data_in_0_ready;
  assign abs_in           = data_in_0[W-1] ? (~data_in_0 + 1'b1) : data_in_0;
  assign data_out_0_valid = (state_q == StEmit);
  assign mdata_out_0      = mdata_q;
  assign edata_out_0      = edata_q;

  // Leading-one position of the block maximum; zero block yields L = 0.
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (max_abs_q[i]) lead = ShW'(i);
    end
  end

  // Mantissas keep the unclamped shift even when the exponent saturates.
  always_comb begin
    shift_right = (lead >= ShW'(M - 2));
    shamt       = shift_right ? (lead - ShW'(M - 2)) : (ShW'(M - 2) - lead);
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      if (shift_right) calc_mant[i] = M'($signed(buffer_q[i]) >>> shamt);
      else             calc_mant[i] = M'(buffer_q[i] << shamt);
    end
    exp_raw = int'(lead) - int'(Frac);
    if (exp_raw > EMax)      exp_sat = EMax;
    else if (exp_raw < EMin) exp_sat = EMin;
    else                     exp_sat = exp_raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_abs_d = max_abs_q;
    buffer_d  = buffer_q;
    mdata_d   = mdata_q;
    edata_d   = edata_q;
    unique case (state_q)
      StCollect: begin
        if (in_accept) begin
          buffer_d[cnt_q] = data_in_0;
          if (abs_in > max_abs_q) max_abs_d = abs_in;
          if (cnt_q == CntW'(BLOCK_SIZE - 1)) begin
            cnt_d   = '0;
            state_d = StCalc;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCalc: begin
        mdata_d = calc_mant;
        edata_d = E'(exp_sat);
        state_d = StEmit;
      end
      StEmit: begin
        if (data_out_0_ready) begin
          max_abs_d = '0;
          state_d   = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StCollect;
      cnt_q     <= '0;
      max_abs_q <= '0;
      mdata_q   <= '{default: '0};
      edata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_abs_q <= max_abs_d;
      mdata_q   <= mdata_d;
      edata_q   <= edata_d;
    end
  end

  // Buffer contents are don't-care until a full block is collected.
  always_ff @(posedge clk) begin
    buffer_q <= buffer_d;
  end

endmodule

// File: tb/tb_mxint_block_quantizer.sv
// Directed, table-driven bench for mxint_block_quantizer at default parameters.
module tb_mxint_block_quantizer;

  typedef struct packed {
    logic [3:0][15:0] din;
    logic [3:0][7:0]  m;
    logic [7:0]       e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  mdata [3:0];
  logic [7:0]  edata;
  logic        dout_valid;
  logic        dout_ready;

  int checks_total;
  int checks_passed;
  vec_t vecs [5];
  vec_t bpv;

  mxint_block_quantizer dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (din),
    .data_in_0_valid  (din_valid),
    .data_in_0_ready  (din_ready),
    .mdata_out_0      (mdata),
    .edata_out_0      (edata),
    .data_out_0_valid (dout_valid),
    .data_out_0_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2, input logic [7:0] m3,
                              input logic [7:0] e);
    vec_t v;
    v.din[0] = d0; v.din[1] = d1; v.din[2] = d2; v.din[3] = d3;
    v.m[0] = m0;   v.m[1] = m1;   v.m[2] = m2;   v.m[3] = m3;
    v.e = e;
    return v;
  endfunction

  task automatic send_elem(input logic [15:0] x);
    int n;
    n = 0;
    @(negedge clk);
    din_valid = 1'b1;
    din       = x;
    while (!din_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) chk("in_ready_timeout", {31'b0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Called right after the last element is accepted.
  task automatic check_emit(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, "_calc_valid"}, {31'b0, dout_valid}, 32'd0);
    chk({tag, "_calc_in_ready"}, {31'b0, din_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_emit_valid"}, {31'b0, dout_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_mant%0d", tag, i), {24'b0, mdata[i]}, {24'b0, v.m[i]});
    end
    chk({tag, "_exp"}, {24'b0, edata}, {24'b0, v.e});
  endtask

  task automatic run_block(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk({tag, "_pre_valid"}, {31'b0, dout_valid}, 32'd0);
      send_elem(v.din[i]);
    end
    check_emit(v, tag);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, {31'b0, dout_valid}, 32'd0);
    chk({tag, "_post_in_ready"}, {31'b0, din_ready}, 32'd1);
  endtask

  initial begin
    logic stable;
    checks_total  = 0;
    checks_passed = 0;
    clk        = 1'b0;
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    vecs[0] = mk(16'h0100, 16'h0080, 16'hFF00, 16'h0040, 8'h40, 8'h20, 8'hC0, 8'h10, 8'h00);
    vecs[1] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8);
    vecs[2] = mk(16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 8'hC0, 8'h00, 8'hFF, 8'h3F, 8'h07);
    vecs[3] = mk(16'h0003, 16'hFFFF, 16'h0001, 16'h0000, 8'h60, 8'hE0, 8'h20, 8'h00, 8'hF9);
    vecs[4] = mk(16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 8'h40, 8'hC0, 8'h00, 8'h40, 8'hF8);
    bpv     = mk(16'h1234, 16'h0000, 16'h0000, 16'h0000, 8'h48, 8'h00, 8'h00, 8'h00, 8'h04);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, din_ready}, 32'd0);
    chk("rst_valid", {31'b0, dout_valid}, 32'd0);
    chk("rst_exp", {24'b0, edata}, 32'd0);
    chk("rst_mant", {mdata[3], mdata[2], mdata[1], mdata[0]}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", {31'b0, din_ready}, 32'd1);

    for (int k = 0; k < 5; k++) begin
      run_block(vecs[k], $sformatf("vec%0d", k));
      handshake($sformatf("vec%0d", k));
    end

    // Backpressure: outputs hold, pending input is not consumed during EMIT
    run_block(vecs[0], "bp");
    @(negedge clk);
    din_valid = 1'b1;
    din       = 16'h1234;
    stable    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!dout_valid || din_ready || edata !== vecs[0].e) stable = 1'b0;
      for (int i = 0; i < 4; i++) if (mdata[i] !== vecs[0].m[i]) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    @(negedge clk);
    chk("bp_post_valid", {31'b0, dout_valid}, 32'd0);
    chk("bp_post_in_ready", {31'b0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    for (int i = 1; i < 4; i++) send_elem(bpv.din[i]);
    check_emit(bpv, "bpnext");
    handshake("bpnext");

    // Reset mid-block discards the partial block
    send_elem(16'h7FFF);
    send_elem(16'h8000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, din_ready}, 32'd0);
    chk("midrst_valid", {31'b0, dout_valid}, 32'd0);
    rst = 1'b1;
    run_block(vecs[0], "midrst");
    handshake("midrst");

    // Reset during EMIT drops the pending block
    run_block(vecs[2], "emitrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("emitrst_valid", {31'b0, dout_valid}, 32'd0);
    chk("emitrst_exp", {24'b0, edata}, 32'd0);
    run_block(vecs[1], "after_emitrst");
    handshake("after_emitrst");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
